// File: rtl/sel_arb_pkg.sv
// Shared mode encodings for the registered channel selector.
package sel_arb_pkg;
  localparam logic [1:0] MODE_FIXED  = 2'b00;
  localparam logic [1:0] MODE_RR     = 2'b01;
  localparam logic [1:0] MODE_FORCED = 2'b10;
endpackage

// File: rtl/sel_arb_reg_if.sv
// Upstream/downstream handshake bundle for sel_arb_reg.
interface sel_arb_reg_if #(
  parameter int N     = 4,
  parameter int WIDTH = 32,
  parameter int SELW  = $clog2(N)
);
  logic [N-1:0]            in_valid;
  logic [N-1:0]            in_ready;
  logic [N-1:0][WIDTH-1:0] in_data;
  logic [1:0]              mode;
  logic [SELW-1:0]         sel;
  logic                    flush;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SELW-1:0]         out_ch;

  modport slave (
    input  in_valid, in_data, mode, sel, flush, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );
  modport master (
    output in_valid, in_data, mode, sel, flush, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/sel_arb_reg_rr_grant.sv
// Combinational grant: fixed / round-robin / forced selection over N requests.
module rr_grant
  import sel_arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  input  logic [1:0]      mode,
  input  logic [SELW-1:0] sel,
  output logic [N-1:0]    grant,
  output logic [SELW-1:0] grant_idx,
  output logic            any_grant
);
  logic [N-1:0]    masked;
  logic [SELW-1:0] hi_idx, lo_idx;
  logic            hi_any, lo_any;

  // Two priority encodes: masked (index >= ptr) first, unmasked as the wrap fallback.
  always_comb begin
    masked = '0;
    hi_idx = '0;
    lo_idx = '0;
    hi_any = 1'b0;
    lo_any = 1'b0;
    for (int i = 0; i < N; i++)
      masked[i] = req[i] & ((SELW+1)'(i) >= {1'b0, ptr});
    for (int i = N-1; i >= 0; i--) begin
      if (masked[i]) begin hi_any = 1'b1; hi_idx = SELW'(i); end
      if (req[i])    begin lo_any = 1'b1; lo_idx = SELW'(i); end
    end
  end

  always_comb begin
    grant_idx = lo_idx;
    any_grant = lo_any;
    grant     = '0;
    case (mode)
      MODE_RR: begin
        grant_idx = hi_any ? hi_idx : lo_idx;
        any_grant = hi_any | lo_any;
      end
      MODE_FORCED: begin
        grant_idx = sel;
        any_grant = 1'b0;
        // Out-of-range sel matches no channel, so it never grants.
        for (int i = 0; i < N; i++)
          if (sel == SELW'(i) && req[i]) any_grant = 1'b1;
      end
      default: ;
    endcase
    for (int i = 0; i < N; i++)
      grant[i] = any_grant & (grant_idx == SELW'(i));
  end
endmodule

// File: rtl/sel_arb_reg.sv
// Registered N-way channel selector: grant, in_ready gating, one-entry output register.
module sel_arb_reg
  import sel_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic           clk,
  input  logic           rstn,
  sel_arb_reg_if.slave   bus
);
  logic [SELW-1:0]  ptr, gidx;
  logic [N-1:0]     grant;
  logic             any_grant, space, acc, xfer;
  logic             vld_q;
  logic [WIDTH-1:0] data_q, data_sel;
  logic [SELW-1:0]  ch_q;

  rr_grant #(.N(N), .SELW(SELW)) u_grant (
    .req       (bus.in_valid),
    .ptr       (ptr),
    .mode      (bus.mode),
    .sel       (bus.sel),
    .grant     (grant),
    .grant_idx (gidx),
    .any_grant (any_grant)
  );

  // rstn gating keeps in_ready low while reset is held.
  assign space = ~vld_q | bus.out_ready;
  assign acc   = space & ~bus.flush & rstn;
  assign xfer  = any_grant & acc;

  assign bus.in_ready  = grant & {N{acc}};
  assign bus.out_valid = vld_q;
  assign bus.out_data  = data_q;
  assign bus.out_ch    = ch_q;

  always_comb begin
    data_sel = '0;
    for (int i = 0; i < N; i++)
      if (gidx == SELW'(i)) data_sel = bus.in_data[i];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      ch_q   <= '0;
    end else if (bus.flush) begin
      vld_q  <= 1'b0;
    end else if (xfer) begin
      vld_q  <= 1'b1;
      data_q <= data_sel;
      ch_q   <= gidx;
    end else if (bus.out_ready) begin
      vld_q  <= 1'b0;
    end
  end

  // Explicit wrap so non-power-of-2 N never lands on an unused index.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      ptr <= '0;
    else if (xfer && bus.mode == MODE_RR)
      ptr <= (gidx == SELW'(N-1)) ? '0 : gidx + 1'b1;
  end
endmodule
